matrix_slot_manager: RTL and testbench

- Storage allocator and slot table that serves the alloc/commit handshake of the matrix generation and input modes.
- Allocates BRAM regions with a bump pointer.
- Enforces a per-dimension matrix limit by reusing the oldest same-size slot.
- Records committed matrices and exposes a registered lookup port for the display and compute modes.

---
 rtl/matrix_slot_manager_if.sv | 40 ++++
 rtl/matrix_slot_manager.sv | 252 +++++++++++++++++++++++++
 tb/tb_matrix_slot_manager.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_slot_manager_if.sv
// Alloc/commit/query bundle between the matrix modes (master) and the slot manager (slave).
interface matrix_slot_manager_if #(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic [7:0]            config_matrices_per_size;
   logic                  clear_all;
   logic                  alloc_req;
   logic [4:0]            alloc_m;
   logic [4:0]            alloc_n;
   logic                  alloc_valid;
   logic [3:0]            alloc_slot;
   logic [ADDR_WIDTH-1:0] alloc_addr;
   logic                  alloc_err;
   logic [1:0]            alloc_err_code;
   logic                  commit_req;
   logic [3:0]            commit_slot;
   logic [4:0]            commit_m;
   logic [4:0]            commit_n;
   logic [ADDR_WIDTH-1:0] commit_addr;
   logic [3:0]            query_slot;
   logic                  query_valid;
   logic [4:0]            query_m;
   logic [4:0]            query_n;
   logic [ADDR_WIDTH-1:0] query_addr;
   logic [4:0]            used_count;

   modport master (
      output config_matrices_per_size, clear_all, alloc_req, alloc_m, alloc_n,
      output commit_req, commit_slot, commit_m, commit_n, commit_addr, query_slot,
      input  alloc_valid, alloc_slot, alloc_addr, alloc_err, alloc_err_code,
      input  query_valid, query_m, query_n, query_addr, used_count
   );

   modport slave (
      input  config_matrices_per_size, clear_all, alloc_req, alloc_m, alloc_n,
      input  commit_req, commit_slot, commit_m, commit_n, commit_addr, query_slot,
      output alloc_valid, alloc_slot, alloc_addr, alloc_err, alloc_err_code,
      output query_valid, query_m, query_n, query_addr, used_count
   );
endinterface

// File: rtl/matrix_slot_manager.sv
// Bump-pointer matrix storage allocator with a slot table, per-size reuse limit and lookup port.
module matrix_slot_manager #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned MEM_DEPTH  = 4096,
   parameter int unsigned NUM_SLOTS  = 16,
   parameter int unsigned MAX_DIM    = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   matrix_slot_manager_if.slave  bus
);

   localparam int unsigned PtrW = ((ADDR_WIDTH > 10) ? ADDR_WIDTH : 10) + 2;
   localparam logic [3:0]  LastIdx = 4'(NUM_SLOTS - 1);

   typedef enum logic [2:0] {StIdle, StCheck, StScan, StDecide, StGrant, StErr} state_e;

   state_e                state_q, state_d;
   logic [NUM_SLOTS-1:0]  valid_q, valid_d, reserved_q, reserved_d;
   logic [4:0]            m_q [NUM_SLOTS];
   logic [4:0]            m_d [NUM_SLOTS];
   logic [4:0]            n_q [NUM_SLOTS];
   logic [4:0]            n_d [NUM_SLOTS];
   logic [ADDR_WIDTH-1:0] addr_q [NUM_SLOTS];
   logic [ADDR_WIDTH-1:0] addr_d [NUM_SLOTS];
   logic [3:0]            age_q [NUM_SLOTS];
   logic [3:0]            age_d [NUM_SLOTS];

   logic [4:0]            req_m_q, req_m_d, req_n_q, req_n_d;
   logic [9:0]            size_q, size_d;
   logic [3:0]            scan_idx_q, scan_idx_d;
   logic [4:0]            match_cnt_q, match_cnt_d;
   logic                  oldest_found_q, oldest_found_d;
   logic [3:0]            oldest_idx_q, oldest_idx_d;
   logic [3:0]            oldest_age_q, oldest_age_d;
   logic                  free_found_q, free_found_d;
   logic [3:0]            first_free_q, first_free_d;
   logic [PtrW-1:0]       free_ptr_q, free_ptr_d;
   logic [3:0]            alloc_slot_q, alloc_slot_d;
   logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
   logic [1:0]            err_code_q, err_code_d;
   logic                  q_valid_q, q_valid_d;
   logic [4:0]            q_m_q, q_m_d, q_n_q, q_n_d;
   logic [ADDR_WIDTH-1:0] q_addr_q, q_addr_d;
   logic [4:0]            used_q, used_d;
   logic [7:0]            limit;

   assign limit = (bus.config_matrices_per_size == 8'd0) ? 8'd1 : bus.config_matrices_per_size;

   always_comb begin
      state_d        = state_q;
      valid_d        = valid_q;
      reserved_d     = reserved_q;
      m_d            = m_q;
      n_d            = n_q;
      addr_d         = addr_q;
      age_d          = age_q;
      req_m_d        = req_m_q;
      req_n_d        = req_n_q;
      size_d         = size_q;
      scan_idx_d     = scan_idx_q;
      match_cnt_d    = match_cnt_q;
      oldest_found_d = oldest_found_q;
      oldest_idx_d   = oldest_idx_q;
      oldest_age_d   = oldest_age_q;
      free_found_d   = free_found_q;
      first_free_d   = first_free_q;
      free_ptr_d     = free_ptr_q;
      alloc_slot_d   = alloc_slot_q;
      alloc_addr_d   = alloc_addr_q;
      err_code_d     = err_code_q;

      unique case (state_q)
         StIdle: begin
            if (bus.alloc_req) begin
               req_m_d    = bus.alloc_m;
               req_n_d    = bus.alloc_n;
               err_code_d = 2'd0;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            if (req_m_q == 5'd0 || req_n_q == 5'd0 ||
                req_m_q > 5'(MAX_DIM) || req_n_q > 5'(MAX_DIM)) begin
               err_code_d = 2'd3;
               state_d    = StErr;
            end else begin
               size_d         = 10'(req_m_q) * 10'(req_n_q);
               scan_idx_d     = 4'd0;
               match_cnt_d    = 5'd0;
               oldest_found_d = 1'b0;
               oldest_idx_d   = 4'd0;
               oldest_age_d   = 4'd0;
               free_found_d   = 1'b0;
               first_free_d   = 4'd0;
               state_d        = StScan;
            end
         end
         StScan: begin
            if (valid_q[scan_idx_q] && m_q[scan_idx_q] == req_m_q &&
                n_q[scan_idx_q] == req_n_q) begin
               match_cnt_d = match_cnt_q + 5'd1;
               // Strictly greater keeps the lowest index on equal ages.
               if (!oldest_found_q || age_q[scan_idx_q] > oldest_age_q) begin
                  oldest_found_d = 1'b1;
                  oldest_idx_d   = scan_idx_q;
                  oldest_age_d   = age_q[scan_idx_q];
               end
            end
            if (!valid_q[scan_idx_q] && !reserved_q[scan_idx_q] && !free_found_q) begin
               free_found_d = 1'b1;
               first_free_d = scan_idx_q;
            end
            if (scan_idx_q == LastIdx) state_d = StDecide;
            else                       scan_idx_d = scan_idx_q + 4'd1;
         end
         StDecide: begin
            if ({3'b000, match_cnt_q} >= limit) begin
               alloc_slot_d = oldest_idx_q;
               alloc_addr_d = addr_q[oldest_idx_q];
               state_d      = StGrant;
            end else if (!free_found_q) begin
               err_code_d = 2'd1;
               state_d    = StErr;
            end else if ((free_ptr_q + PtrW'(size_q)) > PtrW'(MEM_DEPTH)) begin
               err_code_d = 2'd2;
               state_d    = StErr;
            end else begin
               alloc_slot_d             = first_free_q;
               alloc_addr_d             = free_ptr_q[ADDR_WIDTH-1:0];
               reserved_d[first_free_q] = 1'b1;
               free_ptr_d               = free_ptr_q + PtrW'(size_q);
               state_d                  = StGrant;
            end
         end
         StGrant, StErr: state_d = StIdle;
         default:        state_d = StIdle;
      endcase

      if (bus.commit_req && 32'(bus.commit_slot) < NUM_SLOTS) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (4'(i) == bus.commit_slot) begin
               valid_d[i]    = 1'b1;
               reserved_d[i] = 1'b0;
               m_d[i]        = bus.commit_m;
               n_d[i]        = bus.commit_n;
               addr_d[i]     = bus.commit_addr;
               age_d[i]      = 4'd0;
            end else if (valid_q[i] && age_q[i] != 4'hF) begin
               age_d[i] = age_q[i] + 4'd1;
            end
         end
         // Re-entering CHECK clears the scan registers and restarts at index 0.
         if (state_q == StScan) state_d = StCheck;
      end

      if (bus.clear_all) begin
         valid_d    = '0;
         reserved_d = '0;
         free_ptr_d = '0;
         state_d    = StIdle;
         for (int i = 0; i < NUM_SLOTS; i++) age_d[i] = 4'd0;
      end
   end

   always_comb begin
      q_valid_d = 1'b0;
      q_m_d     = 5'd0;
      q_n_d     = 5'd0;
      q_addr_d  = '0;
      if (32'(bus.query_slot) < NUM_SLOTS && valid_q[bus.query_slot]) begin
         q_valid_d = 1'b1;
         q_m_d     = m_q[bus.query_slot];
         q_n_d     = n_q[bus.query_slot];
         q_addr_d  = addr_q[bus.query_slot];
      end
      used_d = 5'd0;
      for (int i = 0; i < NUM_SLOTS; i++) used_d = used_d + 5'(valid_q[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         valid_q        <= '0;
         reserved_q     <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            m_q[i]    <= '0;
            n_q[i]    <= '0;
            addr_q[i] <= '0;
            age_q[i]  <= '0;
         end
         req_m_q        <= '0;
         req_n_q        <= '0;
         size_q         <= '0;
         scan_idx_q     <= '0;
         match_cnt_q    <= '0;
         oldest_found_q <= 1'b0;
         oldest_idx_q   <= '0;
         oldest_age_q   <= '0;
         free_found_q   <= 1'b0;
         first_free_q   <= '0;
         free_ptr_q     <= '0;
         alloc_slot_q   <= '0;
         alloc_addr_q   <= '0;
         err_code_q     <= '0;
         q_valid_q      <= 1'b0;
         q_m_q          <= '0;
         q_n_q          <= '0;
         q_addr_q       <= '0;
         used_q         <= '0;
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         reserved_q     <= reserved_d;
         m_q            <= m_d;
         n_q            <= n_d;
         addr_q         <= addr_d;
         age_q          <= age_d;
         req_m_q        <= req_m_d;
         req_n_q        <= req_n_d;
         size_q         <= size_d;
         scan_idx_q     <= scan_idx_d;
         match_cnt_q    <= match_cnt_d;
         oldest_found_q <= oldest_found_d;
         oldest_idx_q   <= oldest_idx_d;
         oldest_age_q   <= oldest_age_d;
         free_found_q   <= free_found_d;
         first_free_q   <= first_free_d;
         free_ptr_q     <= free_ptr_d;
         alloc_slot_q   <= alloc_slot_d;
         alloc_addr_q   <= alloc_addr_d;
         err_code_q     <= err_code_d;
         q_valid_q      <= q_valid_d;
         q_m_q          <= q_m_d;
         q_n_q          <= q_n_d;
         q_addr_q       <= q_addr_d;
         used_q         <= used_d;
      end
   end

   assign bus.alloc_valid    = (state_q == StGrant);
   assign bus.alloc_err      = (state_q == StErr);
   assign bus.alloc_slot     = alloc_slot_q;
   assign bus.alloc_addr     = alloc_addr_q;
   assign bus.alloc_err_code = err_code_q;
   assign bus.query_valid    = q_valid_q;
   assign bus.query_m        = q_m_q;
   assign bus.query_n        = q_n_q;
   assign bus.query_addr     = q_addr_q;
   assign bus.used_count     = used_q;

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Scoreboard bench for matrix_slot_manager: a slot-table model predicts every alloc and query response.
module tb_matrix_slot_manager;
   localparam int NS   = 16;
   localparam int MEMD = 64;
   localparam int AW   = 12;
   localparam int LAT  = NS + 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_slot_manager_if #(.ADDR_WIDTH(AW)) bus ();

   matrix_slot_manager #(
      .ADDR_WIDTH(AW),
      .MEM_DEPTH (MEMD),
      .NUM_SLOTS (NS),
      .MAX_DIM   (5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {bit is_err; int slot; int addr; int code; int at;} aexp_t;
   typedef struct {bit v; int m; int n; int a; int used;} qexp_t;
   aexp_t aq[$];
   qexp_t qq[$];
   logic  qry_chk = 1'b0;

   // Reference table
   bit mv[NS];
   bit mr[NS];
   int mm[NS], mn[NS], ma[NS], mage[NS];
   int mptr;
   int lim_cfg;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NS; i++) begin
         mv[i] = 0; mr[i] = 0; mage[i] = 0;
      end
      mptr = 0;
   endtask

   task automatic model_commit(input int s, input int m, input int n, input int a);
      for (int i = 0; i < NS; i++)
         if (i != s && mv[i] && mage[i] < 15) mage[i]++;
      mv[s] = 1; mr[s] = 0; mm[s] = m; mn[s] = n; ma[s] = a; mage[s] = 0;
   endtask

   task automatic model_decide(input int m, input int n, output bit is_err, output int slot,
                               output int addr, output int code, output bit reuse,
                               output int size);
      int cnt, best, ff, lim;
      is_err = 0; slot = 0; addr = 0; code = 0; reuse = 0; size = m * n;
      if (m == 0 || n == 0 || m > 5 || n > 5) begin
         is_err = 1; code = 3;
         return;
      end
      cnt = 0; best = -1; ff = -1;
      for (int i = 0; i < NS; i++) begin
         if (mv[i] && mm[i] == m && mn[i] == n) begin
            cnt++;
            if (best < 0 || mage[i] > mage[best]) best = i;
         end
         if (!mv[i] && !mr[i] && ff < 0) ff = i;
      end
      lim = (lim_cfg == 0) ? 1 : lim_cfg;
      if (cnt >= lim) begin
         reuse = 1; slot = best; addr = ma[best];
      end else if (ff < 0) begin
         is_err = 1; code = 1;
      end else if (mptr + size > MEMD) begin
         is_err = 1; code = 2;
      end else begin
         slot = ff; addr = mptr;
      end
   endtask

   task automatic push_alloc(input bit is_err, input int slot, input int addr, input int code,
                             input int at);
      aexp_t e;
      e.is_err = is_err; e.slot = slot; e.addr = addr; e.code = code; e.at = at;
      aq.push_back(e);
   endtask

   task automatic wait_resp();
      bit got = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (bus.alloc_valid || bus.alloc_err) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL alloc_timeout: actual none required response within 80 cycles");
      end
      @(posedge clk); #1;
      bus.alloc_req = 1'b0;
   endtask

   task automatic apply_grant(input bit is_err, input bit reuse, input int slot, input int size);
      if (!is_err && !reuse) begin
         mr[slot] = 1;
         mptr += size;
      end
   endtask

   // Callers start #1 after a rising edge with the FSM idle.
   task automatic do_alloc(input int m, input int n, output bit gerr, output int gslot,
                           output int gaddr);
      bit is_err, reuse;
      int slot, addr, code, size;
      model_decide(m, n, is_err, slot, addr, code, reuse, size);
      push_alloc(is_err, slot, addr, code, cyc + ((code == 3) ? 2 : LAT));
      bus.alloc_m = 5'(m); bus.alloc_n = 5'(n); bus.alloc_req = 1'b1;
      wait_resp();
      apply_grant(is_err, reuse, slot, size);
      gerr = is_err; gslot = slot; gaddr = addr;
   endtask

   task automatic do_pulse(input bit c, input bit clr, input int s, input int m, input int n,
                           input int a);
      bus.commit_req = c; bus.clear_all = clr;
      bus.commit_slot = 4'(s); bus.commit_m = 5'(m); bus.commit_n = 5'(n);
      bus.commit_addr = AW'(a);
      @(posedge clk); #1;
      bus.commit_req = 1'b0; bus.clear_all = 1'b0;
      if (clr) model_clear();
      else if (c) model_commit(s, m, n, a);
   endtask

   task automatic do_query(input int s);
      qexp_t e;
      int used = 0;
      repeat (2) begin @(posedge clk); #1; end
      bus.query_slot = 4'(s);
      for (int i = 0; i < NS; i++) used += int'(mv[i]);
      e.v = mv[s]; e.m = mv[s] ? mm[s] : 0; e.n = mv[s] ? mn[s] : 0; e.a = mv[s] ? ma[s] : 0;
      e.used = used;
      qq.push_back(e);
      @(posedge clk); #1; qry_chk = 1'b1;
      @(posedge clk); #1; qry_chk = 1'b0;
   endtask

   task automatic set_limit(input int l);
      lim_cfg = l;
      bus.config_matrices_per_size = 8'(l);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a response.
   always @(negedge clk) begin : monitor
      aexp_t ae;
      qexp_t qe;
      if (rst_n) begin
         if (bus.alloc_valid || bus.alloc_err) begin
            if (aq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL alloc_unexpected: actual valid=%0b err=%0b required no response",
                        bus.alloc_valid, bus.alloc_err);
            end else begin
               ae = aq.pop_front();
               check("alloc_kind_err", int'(bus.alloc_err), int'(ae.is_err));
               check("alloc_cycle", cyc, ae.at);
               check("alloc_err_code", int'(bus.alloc_err_code), ae.code);
               if (!ae.is_err) begin
                  check("alloc_slot", int'(bus.alloc_slot), ae.slot);
                  check("alloc_addr", int'(bus.alloc_addr), ae.addr);
               end
            end
         end
         if (qry_chk) begin
            if (qq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL query_unexpected: actual strobe required queued entry");
            end else begin
               qe = qq.pop_front();
               check("query_valid", int'(bus.query_valid), int'(qe.v));
               check("query_m", int'(bus.query_m), qe.m);
               check("query_n", int'(bus.query_n), qe.n);
               check("query_addr", int'(bus.query_addr), qe.a);
               check("used_count", int'(bus.used_count), qe.used);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual still running required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit   gerr;
      int   gslot, gaddr, ccyc, r, m, n;
      bit   is_err, reuse;
      int   slot, addr, code, size;

      bus.alloc_req = 0; bus.alloc_m = 0; bus.alloc_n = 0; bus.clear_all = 0;
      bus.commit_req = 0; bus.commit_slot = 0; bus.commit_m = 0; bus.commit_n = 0;
      bus.commit_addr = 0; bus.query_slot = 0;
      set_limit(2);
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_alloc_valid", int'(bus.alloc_valid), 0);
      check("rst_alloc_err", int'(bus.alloc_err), 0);
      check("rst_alloc_slot", int'(bus.alloc_slot), 0);
      check("rst_alloc_addr", int'(bus.alloc_addr), 0);
      check("rst_err_code", int'(bus.alloc_err_code), 0);
      check("rst_query_valid", int'(bus.query_valid), 0);
      check("rst_used_count", int'(bus.used_count), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic grant and bump pointer
      do_alloc(2, 3, gerr, gslot, gaddr);
      do_pulse(1, 0, gslot, 2, 3, gaddr);
      do_alloc(3, 3, gerr, gslot, gaddr);
      do_pulse(1, 0, gslot, 3, 3, gaddr);
      do_query(1);

      // Reuse of the oldest same-size slot
      do_pulse(0, 1, 0, 0, 0, 0);
      do_pulse(1, 0, 0, 2, 2, 0);
      do_pulse(1, 0, 1, 2, 2, 4);
      do_alloc(2, 2, gerr, gslot, gaddr);
      do_pulse(1, 0, 0, 2, 2, 0);
      do_alloc(2, 2, gerr, gslot, gaddr);
      do_alloc(1, 1, gerr, gslot, gaddr);

      // Bad dimensions
      do_alloc(0, 2, gerr, gslot, gaddr);
      do_alloc(6, 1, gerr, gslot, gaddr);
      do_alloc(2, 6, gerr, gslot, gaddr);
      do_query(0);

      // Slot exhaustion, then memory exhaustion
      do_pulse(0, 1, 0, 0, 0, 0);
      set_limit(255);
      for (int i = 0; i < NS + 1; i++) do_alloc(1, 1, gerr, gslot, gaddr);
      do_pulse(0, 1, 0, 0, 0, 0);
      do_alloc(5, 5, gerr, gslot, gaddr);
      do_alloc(5, 5, gerr, gslot, gaddr);
      do_alloc(4, 4, gerr, gslot, gaddr);

      // Commit mid-SCAN restarts the scan
      do_pulse(0, 1, 0, 0, 0, 0);
      set_limit(1);
      do_pulse(1, 0, 3, 2, 2, 40);
      bus.alloc_m = 5'd3; bus.alloc_n = 5'd3; bus.alloc_req = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      ccyc = cyc;
      do_pulse(1, 0, 0, 1, 1, 50);
      model_decide(3, 3, is_err, slot, addr, code, reuse, size);
      push_alloc(is_err, slot, addr, code, ccyc + LAT);
      wait_resp();
      apply_grant(is_err, reuse, slot, size);

      // clear_all wins over a simultaneous commit
      do_pulse(1, 1, 2, 1, 1, 0);
      do_query(2);

      // Lookup after commit, and an empty slot
      do_pulse(1, 0, 1, 3, 4, 12);
      do_query(1);
      do_query(15);

      // Reset in the middle of an allocation drops the reservation and pointer
      do_alloc(2, 2, gerr, gslot, gaddr);
      bus.alloc_m = 5'd3; bus.alloc_n = 5'd3; bus.alloc_req = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      rst_n = 1'b0; bus.alloc_req = 1'b0;
      @(posedge clk); #1;
      check("midrst_alloc_valid", int'(bus.alloc_valid), 0);
      check("midrst_used_count", int'(bus.used_count), 0);
      check("midrst_query_valid", int'(bus.query_valid), 0);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk); #1;
      do_alloc(1, 2, gerr, gslot, gaddr);

      // Randomized traffic
      for (int it = 0; it < 200; it++) begin
         r = $urandom_range(0, 19);
         if (r < 10) begin
            if ($urandom_range(0, 15) == 0) begin
               m = $urandom_range(0, 7); n = $urandom_range(0, 7);
            end else begin
               m = $urandom_range(1, 3); n = $urandom_range(1, 3);
            end
            do_alloc(m, n, gerr, gslot, gaddr);
            if (!gerr && $urandom_range(0, 4) != 0) do_pulse(1, 0, gslot, m, n, gaddr);
         end else if (r < 13) begin
            do_pulse(1, 0, $urandom_range(0, NS - 1), $urandom_range(1, 3),
                     $urandom_range(1, 3), $urandom_range(0, MEMD - 1));
         end else if (r == 13) begin
            do_pulse($urandom_range(0, 1), 1, $urandom_range(0, NS - 1), 1, 1, 0);
         end else if (r < 18) begin
            do_query($urandom_range(0, NS - 1));
         end else begin
            set_limit($urandom_range(0, 3));
         end
      end

      repeat (3) begin @(posedge clk); #1; end
      if (aq.size() != 0 || qq.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: actual %0d entries left required 0",
                  aq.size() + qq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
